// File: rtl/robot_seq_pkg.sv
// Shared definitions for the table-driven robot sequencer: fault codes and
// the packed layout of one transition-table entry.
package robot_seq_pkg;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'd0,
    FLT_WDOG  = 2'd1,
    FLT_BADNX = 2'd2,
    FLT_CFG   = 2'd3
  } fault_code_t;

  // Entry layout, MSB to LSB: {cond_sel, cond_pol, nx_t, nx_f, out_t, out_f}
  function automatic int unsigned entry_w(int unsigned sel_w, int unsigned state_w,
                                          int unsigned num_out);
    return sel_w + 1 + 2 * state_w + 2 * num_out;
  endfunction

  function automatic int unsigned off_out_f();
    return 0;
  endfunction

  function automatic int unsigned off_out_t(int unsigned num_out);
    return num_out;
  endfunction

  function automatic int unsigned off_nx_f(int unsigned num_out);
    return 2 * num_out;
  endfunction

  function automatic int unsigned off_nx_t(int unsigned num_out, int unsigned state_w);
    return 2 * num_out + state_w;
  endfunction

  function automatic int unsigned off_pol(int unsigned num_out, int unsigned state_w);
    return 2 * num_out + 2 * state_w;
  endfunction

  function automatic int unsigned off_sel(int unsigned num_out, int unsigned state_w);
    return 2 * num_out + 2 * state_w + 1;
  endfunction

endpackage

// File: rtl/robot_seq_engine_if.sv
// Configuration bus of the robot sequencer: table write port and reject pulse.
interface robot_seq_engine_if
  import robot_seq_pkg::*;
#(
  parameter int unsigned STATE_W = 6,
  parameter int unsigned ENTRY_W = entry_w(3, 6, 43)
);
  logic               cfg_we;
  logic [STATE_W-1:0] cfg_addr;
  logic [ENTRY_W-1:0] cfg_data;
  logic               cfg_err;

  modport master (output cfg_we, output cfg_addr, output cfg_data, input cfg_err);
  modport slave  (input cfg_we, input cfg_addr, input cfg_data, output cfg_err);
endinterface

// File: rtl/robot_seq_table.sv
// Transition table storage: NUM_STATES entries of async-reset flops with one
// write port and a combinational read port indexed by the current state.
module robot_seq_table #(
  parameter int unsigned NUM_STATES = 47,
  parameter int unsigned STATE_W    = 6,
  parameter int unsigned ENTRY_W    = 102
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [STATE_W-1:0] wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [STATE_W-1:0] rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [NUM_STATES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_STATES; i++) mem[i] <= '0;
    end else if (we && (32'(wr_addr) < NUM_STATES)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < NUM_STATES) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/robot_seq_engine.sv
// Table-driven robot sequencer: evaluates the current entry's condition,
// advances under run/step control, and guards with a self-loop watchdog.
module robot_seq_engine
  import robot_seq_pkg::*;
#(
  parameter int unsigned NUM_IN      = 5,
  parameter int unsigned NUM_OUT     = 43,
  parameter int unsigned NUM_STATES  = 47,
  parameter int unsigned STATE_W     = 6,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned WDOG_W      = 16,
  parameter int unsigned WDOG_LIMIT  = 1000,
  parameter int unsigned START_STATE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  x,
  input  logic               run,
  input  logic               step_mode,
  input  logic               step,
  input  logic               clr_fault,
  robot_seq_engine_if.slave  cfg,
  output logic [NUM_OUT-1:0] y,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int unsigned ENTRY_W = entry_w(SEL_W, STATE_W, NUM_OUT);
  localparam int unsigned O_OUTF  = off_out_f();
  localparam int unsigned O_OUTT  = off_out_t(NUM_OUT);
  localparam int unsigned O_NXF   = off_nx_f(NUM_OUT);
  localparam int unsigned O_NXT   = off_nx_t(NUM_OUT, STATE_W);
  localparam int unsigned O_POL   = off_pol(NUM_OUT, STATE_W);
  localparam int unsigned O_SEL   = off_sel(NUM_OUT, STATE_W);

  logic [ENTRY_W-1:0] cur;
  logic [SEL_W-1:0]   sel;
  logic               pol;
  logic [STATE_W-1:0] nx_t, nx_f, tgt;
  logic [NUM_OUT-1:0] out_t, out_f, out_sel;
  logic               sel_hit, cond, adv, self_loop, bad_tgt, wdog_trip, cfg_reject;
  logic [WDOG_W-1:0]  wdog, wdog_inc;

  robot_seq_table #(
    .NUM_STATES (NUM_STATES),
    .STATE_W    (STATE_W),
    .ENTRY_W    (ENTRY_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg.cfg_we & ~run),
    .wr_addr (cfg.cfg_addr),
    .wr_data (cfg.cfg_data),
    .rd_addr (state),
    .rd_data (cur)
  );

  assign sel   = cur[O_SEL +: SEL_W];
  assign pol   = cur[O_POL];
  assign nx_t  = cur[O_NXT +: STATE_W];
  assign nx_f  = cur[O_NXF +: STATE_W];
  assign out_t = cur[O_OUTT +: NUM_OUT];
  assign out_f = cur[O_OUTF +: NUM_OUT];

  // Selects beyond NUM_IN read as a false input before polarity is applied.
  always_comb begin
    sel_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(sel) == k + 1) sel_hit = x[k];
    end
    cond = (sel == '0) ? 1'b1 : (sel_hit ^ pol);
  end

  assign tgt        = cond ? nx_t : nx_f;
  assign out_sel    = cond ? out_t : out_f;
  assign adv        = run & ~fault & (~step_mode | step);
  assign self_loop  = (tgt == state);
  assign bad_tgt    = (32'(tgt) >= NUM_STATES);
  assign wdog_inc   = wdog + WDOG_W'(1);
  assign wdog_trip  = self_loop && (WDOG_LIMIT != 0) && (32'(wdog_inc) >= WDOG_LIMIT);
  assign cfg_reject = cfg.cfg_we & run;

  // Priority chain: clear, then rejected write, then bad target, then watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= STATE_W'(START_STATE);
      y           <= '0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FLT_NONE;
      cfg.cfg_err <= 1'b0;
      wdog        <= '0;
    end else begin
      cfg.cfg_err <= cfg_reject;
      if (clr_fault) begin
        state      <= STATE_W'(START_STATE);
        y          <= '0;
        busy       <= 1'b0;
        fault      <= 1'b0;
        fault_code <= FLT_NONE;
        wdog       <= '0;
      end else if (cfg_reject && !fault) begin
        y          <= '0;
        busy       <= 1'b0;
        fault      <= 1'b1;
        fault_code <= FLT_CFG;
      end else if (adv) begin
        if (bad_tgt) begin
          y          <= '0;
          busy       <= 1'b0;
          fault      <= 1'b1;
          fault_code <= FLT_BADNX;
        end else if (wdog_trip) begin
          y          <= '0;
          busy       <= 1'b0;
          fault      <= 1'b1;
          fault_code <= FLT_WDOG;
          wdog       <= wdog_inc;
        end else begin
          state <= tgt;
          y     <= out_sel;
          busy  <= 1'b1;
          wdog  <= self_loop ? wdog_inc : '0;
        end
      end else begin
        y    <= '0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_robot_seq_engine.sv
// Self-checking bench for robot_seq_engine: directed scenarios plus randomized
// traffic against a behavioural model of the sequencing rules.
module tb_robot_seq_engine;

  localparam int NS    = 47;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [2:0]  sel;
    logic        pol;
    logic [5:0]  nxt;
    logic [5:0]  nxf;
    logic [42:0] outt;
    logic [42:0] outf;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  x = '0;
  logic        run = 1'b0, step_mode = 1'b0, step = 1'b0, clr_fault = 1'b0;
  logic [42:0] y;
  logic [5:0]  state;
  logic        busy, fault;
  logic [1:0]  fault_code;

  robot_seq_engine_if #(.STATE_W(6), .ENTRY_W(102)) cif();

  robot_seq_engine #(.WDOG_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .run        (run),
    .step_mode  (step_mode),
    .step       (step),
    .clr_fault  (clr_fault),
    .cfg        (cif),
    .y          (y),
    .state      (state),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  entry_t      m_tab [NS];
  int          m_state, m_wdog;
  bit          m_fault;
  logic [1:0]  e_code;
  logic [42:0] e_y;
  bit          e_busy, e_cerr;

  function automatic entry_t mk(int sel, int pol, int nxt, int nxf, logic [42:0] ot, logic [42:0] of);
    entry_t e;
    e.sel = 3'(sel); e.pol = 1'(pol); e.nxt = 6'(nxt); e.nxf = 6'(nxf);
    e.outt = ot; e.outf = of;
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) m_tab[i] = '0;
    m_state = 0; m_wdog = 0; m_fault = 0; e_code = 0; e_y = '0; e_busy = 0; e_cerr = 0;
  endfunction

  function automatic void model_step(bit r, bit sm, bit st, bit clr, bit we,
                                     logic [4:0] xv, int a, entry_t e);
    entry_t c; int tgt; logic [42:0] o; bit cnd;
    e_cerr = we && r;
    if (we && !r && a < NS) m_tab[a] = e;
    if (clr) begin
      m_state = 0; m_fault = 0; e_code = 0; m_wdog = 0; e_y = '0; e_busy = 0;
    end else if (we && r && !m_fault) begin
      m_fault = 1; e_code = 3; e_y = '0; e_busy = 0;
    end else if (r && !m_fault && (!sm || st)) begin
      c = m_tab[m_state];
      if (c.sel == 0) cnd = 1;
      else if (c.sel <= 5) cnd = xv[c.sel - 1] ^ c.pol;
      else cnd = c.pol;
      tgt = cnd ? int'(c.nxt) : int'(c.nxf);
      o   = cnd ? c.outt : c.outf;
      if (tgt >= NS) begin
        m_fault = 1; e_code = 2; e_y = '0; e_busy = 0;
      end else if (tgt == m_state && m_wdog + 1 >= LIMIT) begin
        m_fault = 1; e_code = 1; e_y = '0; e_busy = 0; m_wdog++;
      end else begin
        e_busy = 1; e_y = o;
        m_wdog = (tgt == m_state) ? m_wdog + 1 : 0;
        m_state = tgt;
      end
    end else begin
      e_y = '0; e_busy = 0;
    end
  endfunction

  task automatic tick(input bit r, input bit sm, input bit st, input bit clr, input bit we,
                      input logic [4:0] xv, input int a, input entry_t e);
    @(negedge clk);
    run = r; step_mode = sm; step = st; clr_fault = clr; x = xv;
    cif.cfg_we = we; cif.cfg_addr = 6'(a); cif.cfg_data = e;
    model_step(r, sm, st, clr, we, xv, a, e);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input entry_t e);
    tick(0, 0, 0, 0, 1, '0, a, e);
  endtask

  task automatic go(input logic [4:0] xv);
    tick(1, 0, 0, 0, 0, xv, 0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 0; run = 0; step_mode = 0; step = 0; clr_fault = 0; x = '0;
    cif.cfg_we = 0; cif.cfg_addr = '0; cif.cfg_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    checks++; if (state !== 6'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got=%h exp=0", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (fault_code !== 2'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", fault_code); end
    checks++; if (cif.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cif.cfg_err); end
  endtask

  task automatic test_two_state();
    apply_reset();
    load(0, mk(4, 0, 1, 0, 43'h7000, '0));
    load(1, mk(0, 0, 0, 0, 43'h10000, '0));
    go(5'b01000);
    checks++; if (y !== 43'h7000) begin errors++; $display("FAIL two_state_y1 got=%h exp=7000", y); end
    checks++; if (state !== 6'd1) begin errors++; $display("FAIL two_state_s1 got=%0d exp=1", state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL two_state_busy got=%b exp=1", busy); end
    go(5'b01000);
    checks++; if (y !== 43'h10000) begin errors++; $display("FAIL two_state_y2 got=%h exp=10000", y); end
    checks++; if (state !== 6'd0) begin errors++; $display("FAIL two_state_s2 got=%0d exp=0", state); end
    tick(0, 0, 0, 0, 0, 5'b01000, 0, '0);
    checks++; if (y !== '0 || busy !== 1'b0) begin errors++; $display("FAIL two_state_idle y=%h busy=%b exp 0/0", y, busy); end
  endtask

  task automatic test_polarity();
    apply_reset();
    load(0, mk(1, 1, 2, 3, 43'h1, 43'h2));
    go(5'b00000);
    checks++; if (state !== 6'd2 || y !== 43'h1) begin errors++; $display("FAIL pol_x0 state=%0d y=%h exp 2/1", state, y); end
    go(5'b00000);
    checks++; if (state !== 6'd0) begin errors++; $display("FAIL pol_back state=%0d exp=0", state); end
    go(5'b00001);
    checks++; if (state !== 6'd3 || y !== 43'h2) begin errors++; $display("FAIL pol_x1 state=%0d y=%h exp 3/2", state, y); end
  endtask

  task automatic test_single_step();
    int pulses = 0;
    bit st;
    apply_reset();
    load(0, mk(4, 0, 1, 0, 43'h7000, '0));
    load(1, mk(0, 0, 0, 0, 43'h10000, '0));
    for (int i = 0; i < 16; i++) begin
      st = (i == 0 || i == 5 || i == 10);
      tick(1, 1, st, 0, 0, 5'b01000, 0, '0);
      if (busy === 1'b1) pulses++;
      checks++; if (busy !== e_busy || state !== 6'(m_state) || y !== e_y) begin
        errors++; $display("FAIL step_cyc%0d busy=%b state=%0d y=%h exp %b/%0d/%h", i, busy, state, y, e_busy, m_state, e_y);
      end
      checks++; if (st != busy) begin errors++; $display("FAIL step_pulse%0d busy=%b exp=%b", i, busy, st); end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL step_count got=%0d exp=3", pulses); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    load(0, mk(0, 0, 0, 0, 43'hAB, '0));
    for (int i = 1; i <= LIMIT; i++) begin
      go('0);
      if (i < LIMIT) begin
        checks++; if (y !== 43'hAB || fault !== 1'b0) begin errors++; $display("FAIL wdog_adv%0d y=%h fault=%b exp ab/0", i, y, fault); end
      end else begin
        checks++; if (y !== '0 || fault !== 1'b1 || fault_code !== 2'd1) begin
          errors++; $display("FAIL wdog_trip y=%h fault=%b code=%0d exp 0/1/1", y, fault, fault_code);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      go('0);
      checks++; if (y !== '0 || fault !== 1'b1) begin errors++; $display("FAIL wdog_sticky y=%h fault=%b exp 0/1", y, fault); end
    end
    tick(1, 0, 0, 1, 0, '0, 0, '0);
    checks++; if (state !== 6'd0 || fault !== 1'b0 || fault_code !== 2'd0 || y !== '0) begin
      errors++; $display("FAIL wdog_clr state=%0d fault=%b code=%0d y=%h exp 0/0/0/0", state, fault, fault_code, y);
    end
    go('0);
    checks++; if (y !== 43'hAB) begin errors++; $display("FAIL wdog_resume y=%h exp=ab", y); end
  endtask

  task automatic test_bad_target();
    apply_reset();
    load(0, mk(0, 0, 50, 0, 43'h1, '0));
    go('0);
    checks++; if (fault !== 1'b1 || fault_code !== 2'd2) begin errors++; $display("FAIL badnx_code fault=%b code=%0d exp 1/2", fault, fault_code); end
    checks++; if (state !== 6'd0 || y !== '0) begin errors++; $display("FAIL badnx_hold state=%0d y=%h exp 0/0", state, y); end
  endtask

  task automatic test_cfg_run();
    apply_reset();
    load(0, mk(0, 0, 1, 0, 43'h5, '0));
    tick(1, 1, 0, 0, 1, '0, 0, mk(0, 0, 2, 0, 43'h99, '0));
    checks++; if (cif.cfg_err !== 1'b1) begin errors++; $display("FAIL cfgrun_err got=%b exp=1", cif.cfg_err); end
    checks++; if (fault !== 1'b1 || fault_code !== 2'd3) begin errors++; $display("FAIL cfgrun_code fault=%b code=%0d exp 1/3", fault, fault_code); end
    tick(0, 0, 0, 1, 0, '0, 0, '0);
    checks++; if (cif.cfg_err !== 1'b0) begin errors++; $display("FAIL cfgrun_pulse got=%b exp=0", cif.cfg_err); end
    go('0);
    checks++; if (y !== 43'h5 || state !== 6'd1) begin errors++; $display("FAIL cfgrun_entry y=%h state=%0d exp 5/1", y, state); end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    for (int i = 0; i < 5; i++) load(i, mk(0, 0, i + 1, 0, 43'(1) << i, '0));
    for (int i = 0; i < 5; i++) go('0);
    checks++; if (state !== 6'd5 || y !== 43'h10) begin errors++; $display("FAIL midrst_pre state=%0d y=%h exp 5/10", state, y); end
    #2 rst = 0;
    #1;
    checks++; if (state !== 6'd0 || y !== '0) begin errors++; $display("FAIL midrst_async state=%0d y=%h exp 0/0", state, y); end
    model_reset();
    @(negedge clk);
    rst = 1;
    go('0);
    checks++; if (y !== '0 || state !== 6'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_cleared y=%h state=%0d busy=%b exp 0/0/1", y, state, busy);
    end
  endtask

  function automatic entry_t rnd_entry();
    entry_t e;
    e.sel  = 3'($urandom_range(0, 7));
    e.pol  = 1'($urandom_range(0, 1));
    e.nxt  = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(47, 63)) : 6'($urandom_range(0, 7));
    e.nxf  = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(47, 63)) : 6'($urandom_range(0, 7));
    e.outt = {11'($urandom), 32'($urandom)};
    e.outf = {11'($urandom), 32'($urandom)};
    return e;
  endfunction

  task automatic test_random();
    bit r, st, clr, we, sm;
    apply_reset();
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 8; i++) load(i, rnd_entry());
      tick(0, 0, 0, 1, 0, '0, 0, '0);
      sm = blk[0];
      for (int c = 0; c < 60; c++) begin
        r   = ($urandom_range(0, 7) != 0);
        st  = ($urandom_range(0, 2) == 0);
        clr = ($urandom_range(0, 15) == 0);
        we  = ($urandom_range(0, 39) == 0);
        tick(r, sm, st, clr, we, 5'($urandom), int'($urandom_range(0, 63)), rnd_entry());
        checks++; if (y !== e_y) begin errors++; $display("FAIL rnd_y b%0d c%0d got=%h exp=%h", blk, c, y, e_y); end
        checks++; if (state !== 6'(m_state)) begin errors++; $display("FAIL rnd_state b%0d c%0d got=%0d exp=%0d", blk, c, state, m_state); end
        checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy b%0d c%0d got=%b exp=%b", blk, c, busy, e_busy); end
        checks++; if (fault !== m_fault) begin errors++; $display("FAIL rnd_fault b%0d c%0d got=%b exp=%b", blk, c, fault, m_fault); end
        checks++; if (fault_code !== e_code) begin errors++; $display("FAIL rnd_code b%0d c%0d got=%0d exp=%0d", blk, c, fault_code, e_code); end
        checks++; if (cif.cfg_err !== e_cerr) begin errors++; $display("FAIL rnd_cfg_err b%0d c%0d got=%b exp=%b", blk, c, cif.cfg_err, e_cerr); end
      end
    end
  endtask

  initial begin
    cif.cfg_we = 0; cif.cfg_addr = '0; cif.cfg_data = '0;
    model_reset();
    test_reset();
    test_two_state();
    test_polarity();
    test_single_step();
    test_watchdog();
    test_bad_target();
    test_cfg_run();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robot_seq_engine.md
Name: robot_seq_engine

Overview:
Table-driven, parametrised successor to the fixed-encoding robot controller FSMs in the Small FSM benchmark set. Each state's behaviour is held in a loadable transition table: one condition test, two branch targets and two output words. Software can load any robot sequence of up to NUM_STATES states without re-synthesis. Adds registered outputs, run/single-step control, a self-loop watchdog and fault reporting, none of which the fixed controllers have.

Parameters:
NUM_IN, 5, number of sensor inputs x[NUM_IN-1:0]
NUM_OUT, 43, number of actuator outputs y[NUM_OUT-1:0]
NUM_STATES, 47, table depth; legal states 0..NUM_STATES-1
STATE_W, 6, state index width; must satisfy 2^STATE_W >= NUM_STATES
SEL_W, 3, condition-select width; must satisfy 2^SEL_W >= NUM_IN+1
WDOG_W, 16, watchdog counter width
WDOG_LIMIT, 1000, self-loop cycles before fault; 0 disables the watchdog
START_STATE, 0, state entered on reset and on fault clear

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  asynchronous, active-low reset
x  in  NUM_IN  sensor inputs, already synchronous to clk
run  in  1  engine enable
step_mode  in  1  1 = advance only on step pulses
step  in  1  single-cycle advance request, used only when step_mode=1
cfg_we  in  1  table write strobe
cfg_addr  in  STATE_W  table entry index
cfg_data  in  ENTRY_W  entry contents; field layout is defined in the package
clr_fault  in  1  clears fault and returns to START_STATE
y  out  NUM_OUT  registered Mealy outputs, one-cycle pulse per transition
state  out  STATE_W  current state
busy  out  1  an advance occurred this cycle (registered)
fault  out  1  sticky fault flag
fault_code  out  2  0 none, 1 watchdog, 2 bad next state, 3 cfg write while running
cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst=0, asynchronous): state=START_STATE, y=0, busy=0, fault=0, fault_code=0, cfg_err=0, wdog=0. All table entries clear to 0 (cond_sel=0 always-true, both targets 0, outputs 0).
- Entry fields:
  - cond_sel[SEL_W]: 0 = always true; k = test x[k-1]; k>NUM_IN reads as false.
  - cond_pol[1]: 1 inverts the selected input.
  - nx_t and nx_f[STATE_W].
  - out_t and out_f[NUM_OUT].
  - ENTRY_W = SEL_W+1+2*STATE_W+2*NUM_OUT.
- Advance condition: adv = run & ~fault & (~step_mode | step).
- On adv, with cond evaluated from the entry of the current state:
  - cond=1: y<=out_t, state<=nx_t.
  - cond=0: y<=out_f, state<=nx_f.
  - busy<=1.
  - Latency: x sampled at edge N gives y and state visible after edge N.
- No adv: y<=0, busy<=0, state holds. Outputs are pulses, never levels.
- Bad target: if the selected target is >= NUM_STATES, the engine does not move; y<=0, fault<=1, fault_code<=2.
- Watchdog:
  - wdog increments on each adv whose target equals the current state.
  - It clears on any adv to a different state, and on clr_fault.
  - It holds when there is no adv.
  - When wdog reaches WDOG_LIMIT (non-zero) on an adv: fault<=1, fault_code<=1, y<=0 that cycle.
- Fault is sticky; y stays 0.
  - clr_fault=1: state<=START_STATE, fault<=0, fault_code<=0, wdog<=0. No advance that cycle.
  - clr_fault with adv in the same cycle: clr_fault wins.
- Config writes:
  - Accepted only when run=0: entry[cfg_addr]<=cfg_data; cfg_addr>=NUM_STATES is ignored silently.
  - cfg_we with run=1: write dropped, cfg_err pulses; if fault=0, then fault<=1 and fault_code<=3.
  - A write to the current state's entry takes effect from the next cycle.
- Fault priority within one cycle: 3 > 2 > 1. Only the first fault is recorded until cleared.
- step held high in step_mode advances every cycle (level-sensitive); the stimulus is responsible for pulsing it.

Decomposition:
- Package robot_seq_pkg holds:
  - ENTRY_W computation and field offset/width functions.
  - The fault_code constants FLT_NONE, FLT_WDOG, FLT_BADNX, FLT_CFG.
- Sub-module robot_seq_table holds storage plus the write port and the combinational read mux indexed by state. It has async-reset flops, NUM_STATES x ENTRY_W.
- Top level holds condition evaluation, the state register, the watchdog and fault logic.

Test Plan:
- Two-state load, x4 and x1 tests:
  - Setup: state 0 is {sel=4, pol=0, nx_t=1, nx_f=0, out_t=bits 12,13,14}; state 1 is {sel=0, nx_t=0, out_t=bit 16}.
  - Stimulus: run=1, x4=1.
  - Response: y=0x7000 then 0x10000, state 0->1->0.
- Inverted polarity:
  - Setup: state 0 sel=1, pol=1.
  - Response: x1=0 takes nx_t; x1=1 takes nx_f with out_f.
- Single-step:
  - Stimulus: step_mode=1, run=1, three step pulses spaced 5 cycles apart.
  - Response: exactly 3 busy pulses, state changes only on those edges, y=0 elsewhere.
- Watchdog:
  - Setup: WDOG_LIMIT=4, state 0 self-loops, always true.
  - Response: fault=1, fault_code=1 after the 4th adv, y=0 from then on.
  - Then clr_fault -> state=0, fault=0.
- Bad target and cfg-while-running:
  - nx_t=50 with NUM_STATES=47 -> fault_code=2 and state unchanged.
  - Separately, cfg_we with run=1 -> cfg_err pulse, fault_code=3, entry unchanged on readback via execution.
- Reset mid-run: assert rst=0 asynchronously between edges while at state 5 -> state=0, y=0, all table entries cleared (next adv produces y=0 and stays at 0).
